// File: rtl/line_clear_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : line_clear_sequencer
// Brief    : Removes full rows from the board-colour RAM (bottom-up scan, shift
//            down, blank top row), yielding the shared RAM port to video reads.
// Revision : 1.0 - initial release
// ============================================================================
module line_clear_sequencer #(
  parameter int COLS = 10,
  parameter int ROWS = 20,
  parameter int AW   = 8,
  parameter int DW   = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  input  logic [DW-1:0] ram_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  output logic          busy,
  output logic          done,
  output logic [1:0]    phase,
  output logic [2:0]    lines_cleared
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(COLS + 1);
  localparam logic [RW-1:0] c_last_row = RW'(ROWS - 1);
  localparam logic [CW-1:0] c_last_col = CW'(COLS - 1);
  localparam logic [CW-1:0] c_ncols    = CW'(COLS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_SHIFT = 3'd2,
    S_CLEAR = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [RW-1:0]  row_q, row_d;
  logic [RW-1:0]  dst_q, dst_d;
  logic [CW-1:0]  col_q, col_d;
  logic           wph_q, wph_d;
  logic           full_q, full_d;
  logic [2:0]     lines_q, lines_d;
  logic           rd_pend_q;
  logic [DW-1:0]  cap_q;
  logic           busy_q, done_q;
  logic [1:0]     phase_q, phase_d;

  logic           w_eng_re, w_eng_we;
  logic [AW-1:0]  w_eng_addr;
  logic [DW-1:0]  w_eng_wdata;
  logic [DW-1:0]  w_cap_data;
  logic           w_full;

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r,
                                               input logic [CW-1:0] c);
    return AW'(int'(r) * COLS + int'(c));
  endfunction

  // Data read in the previous engine cycle is taken straight off the RAM bus,
  // so a shift write can follow its read on the very next free cycle.
  assign w_cap_data = rd_pend_q ? ram_rdata : cap_q;
  assign w_full     = full_q & (~rd_pend_q | (|ram_rdata));

  always_comb begin
    w_eng_re    = 1'b0;
    w_eng_we    = 1'b0;
    w_eng_addr  = '0;
    w_eng_wdata = '0;
    case (state_q)
      S_SCAN: begin
        if (col_q != c_ncols) begin
          w_eng_re   = 1'b1;
          w_eng_addr = cell_addr(row_q, col_q);
        end
      end
      S_SHIFT: begin
        if (!wph_q) begin
          w_eng_re   = 1'b1;
          w_eng_addr = cell_addr(dst_q - 1'b1, col_q);
        end else begin
          w_eng_we    = 1'b1;
          w_eng_addr  = cell_addr(dst_q, col_q);
          w_eng_wdata = w_cap_data;
        end
      end
      S_CLEAR: begin
        w_eng_we   = 1'b1;
        w_eng_addr = cell_addr('0, col_q);
      end
      default: ;
    endcase
  end

  assign ram_addr  = vid_req ? vid_addr : w_eng_addr;
  assign ram_we    = w_eng_we & ~vid_req;
  assign ram_wdata = w_eng_wdata;

  // Only port-using states stall on video; IDLE/DONE never do, keeping done one cycle.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dst_d   = dst_q;
    col_d   = col_q;
    wph_d   = wph_q;
    lines_d = lines_q;
    full_d  = w_full;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          row_d   = c_last_row;
          col_d   = '0;
          full_d  = 1'b1;
          lines_d = '0;
        end
      end
      S_SCAN: begin
        if (!vid_req) begin
          if (col_q != c_ncols) begin
            col_d = col_q + 1'b1;
          end else begin
            col_d  = '0;
            full_d = 1'b1;
            if (w_full) begin
              if (row_q == '0) begin
                state_d = S_CLEAR;
              end else begin
                state_d = S_SHIFT;
                dst_d   = row_q;
                wph_d   = 1'b0;
              end
            end else if (row_q == '0) begin
              state_d = S_DONE;
            end else begin
              row_d = row_q - 1'b1;
            end
          end
        end
      end
      S_SHIFT: begin
        if (!vid_req) begin
          wph_d = ~wph_q;
          if (wph_q) begin
            if (col_q == c_last_col) begin
              col_d = '0;
              if (dst_q == RW'(1)) state_d = S_CLEAR;
              else                 dst_d   = dst_q - 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      S_CLEAR: begin
        if (!vid_req) begin
          if (col_q == c_last_col) begin
            col_d   = '0;
            full_d  = 1'b1;
            state_d = S_SCAN;
            lines_d = (lines_q == 3'd7) ? lines_q : lines_q + 3'd1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    phase_d = 2'd0;
    case (state_d)
      S_SCAN:  phase_d = 2'd1;
      S_SHIFT: phase_d = 2'd2;
      S_CLEAR: phase_d = 2'd3;
      default: phase_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      dst_q     <= '0;
      col_q     <= '0;
      wph_q     <= 1'b0;
      full_q    <= 1'b1;
      lines_q   <= '0;
      rd_pend_q <= 1'b0;
      cap_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      phase_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      dst_q     <= dst_d;
      col_q     <= col_d;
      wph_q     <= wph_d;
      full_q    <= full_d;
      lines_q   <= lines_d;
      rd_pend_q <= w_eng_re & ~vid_req;
      cap_q     <= w_cap_data;
      busy_q    <= (state_d == S_SCAN) || (state_d == S_SHIFT) || (state_d == S_CLEAR);
      done_q    <= (state_d == S_DONE);
      phase_q   <= phase_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign phase         = phase_q;
  assign lines_cleared = lines_q;

endmodule
`default_nettype wire

// File: tb/tb_line_clear_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_clear_sequencer
// Brief    : Scoreboard bench for line_clear_sequencer with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_clear_sequencer;

  localparam int COLS  = 10;
  localparam int ROWS  = 20;
  localparam int AW    = 8;
  localparam int DW    = 24;
  localparam int NCELL = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] ram_rdata = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic          busy, done;
  logic [1:0]    phase;
  logic [2:0]    lines_cleared;

  line_clear_sequencer #(.COLS(COLS), .ROWS(ROWS), .AW(AW), .DW(DW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .vid_req(vid_req), .vid_addr(vid_addr),
    .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .busy(busy), .done(done), .phase(phase), .lines_cleared(lines_cleared)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem      [NCELL];
  logic [DW-1:0] init_mem [NCELL];
  logic [DW-1:0] exp_mem  [NCELL];
  logic          load_en = 1'b0;
  logic          toggle  = 1'b0;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < NCELL; i++) mem[i] <= init_mem[i];
    end else if (ram_we && int'(ram_addr) < NCELL) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= (int'(ram_addr) < NCELL) ? mem[ram_addr] : '0;
  end

  always @(negedge clk) begin
    if (toggle) begin
      vid_req  = ~vid_req;
      vid_addr = AW'($urandom_range(0, NCELL - 1));
    end else begin
      vid_req  = 1'b0;
      vid_addr = '0;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  typedef struct { int lines; int done_cyc; } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int busy_cnt = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #1;
    if (busy)   busy_cnt++;
    if (ram_we) we_cnt++;
    if (vid_req) begin
      chk("vid_we", 32'(ram_we), 32'd0);
      chk("vid_addr", 32'(ram_addr), 32'(vid_addr));
    end
    if (done) begin
      exp_t e;
      int   bad;
      done_cnt++;
      last_done_cyc = cyc;
      chk("sb_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("lines", 32'(lines_cleared), 32'(e.lines));
        chk("done_busy", 32'(busy), 32'd0);
        if (e.done_cyc >= 0) chk("done_cyc", 32'(cyc), 32'(e.done_cyc));
        bad = 0;
        for (int i = 0; i < NCELL; i++) if (mem[i] !== exp_mem[i]) bad++;
        chk("ram_bad_cells", 32'(bad), 32'd0);
      end
    end
  end

  task automatic model_clear(output int nl);
    int dst;
    dst = ROWS - 1;
    nl  = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      bit full;
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (init_mem[r*COLS + c] == '0) full = 1'b0;
      if (full) begin
        nl++;
      end else begin
        for (int c = 0; c < COLS; c++) exp_mem[dst*COLS + c] = init_mem[r*COLS + c];
        dst--;
      end
    end
    for (int r = dst; r >= 0; r--)
      for (int c = 0; c < COLS; c++) exp_mem[r*COLS + c] = '0;
    if (nl > 7) nl = 7;
  endtask

  task automatic board_clear();
    for (int i = 0; i < NCELL; i++) init_mem[i] = '0;
  endtask

  task automatic board_t2();
    board_clear();
    for (int c = 0; c < COLS; c++) init_mem[19*COLS + c] = 24'h66B2FF;
    init_mem[18*COLS + 3] = 24'hFF3399;
  endtask

  task automatic board_t3();
    board_clear();
    for (int c = 0; c < COLS; c++) begin
      init_mem[19*COLS + c] = 24'h66B2FF;
      init_mem[17*COLS + c] = 24'h66B2FF;
    end
    init_mem[18*COLS + 0] = 24'h00FF00;
  endtask

  task automatic load_board();
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Loads init_mem, fires start, and returns once done is seen (or the bound expires).
  task automatic run_pass(input bit timed, output int dur);
    int nl, base, t0;
    exp_t e;
    model_clear(nl);
    load_board();
    @(negedge clk);
    base     = done_cnt;
    busy_cnt = 0;
    we_cnt   = 0;
    start    = 1'b1;
    t0       = cyc + 1;
    e.lines    = nl;
    e.done_cyc = timed ? (cyc + 221) : -1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4000 && done_cnt == base; k++) begin
      @(negedge clk);
      #2;
    end
    chk("wait_done", 32'(done_cnt - base), 32'd1);
    dur = last_done_cyc - t0;
  endtask

  int d_t1, d_t2, d_t3, d_t4, d_t5, d_t6;
  int base5;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_lines", 32'(lines_cleared), 32'd0);
    chk("rst_we",    32'(ram_we), 32'd0);
    chk("rst_wdata", 32'(ram_wdata), 32'd0);
    rst = 1'b1;

    // Empty board: exact timing, no writes.
    board_clear();
    run_pass(1'b1, d_t1);
    chk("t1_busy_cycles", 32'(busy_cnt), 32'd220);
    chk("t1_writes", 32'(we_cnt), 32'd0);

    board_t2();
    run_pass(1'b0, d_t2);
    chk("t2_row19_col3", 32'(mem[19*COLS + 3]), 32'hFF3399);
    chk("t2_row19_col0", 32'(mem[19*COLS + 0]), 32'h0);

    board_t3();
    run_pass(1'b0, d_t3);
    chk("t3_row19_col0", 32'(mem[19*COLS + 0]), 32'h00FF00);

    // Video port alternating with the engine.
    board_t2();
    toggle = 1'b1;
    run_pass(1'b0, d_t4);
    toggle = 1'b0;
    chk("t4_slowdown", 32'(d_t4 * 2 > d_t2 * 3 && d_t4 * 2 < d_t2 * 5), 32'd1);

    // Extra start pulses while busy must be ignored.
    board_t2();
    fork
      run_pass(1'b0, d_t5);
      begin
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    base5 = done_cnt;
    repeat (300) @(negedge clk);
    #2;
    chk("t5_no_extra_done", 32'(done_cnt - base5), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);

    // Reset during the second shift of a two-line pass.
    board_t3();
    begin
      int nl;
      exp_t e;
      model_clear(nl);
      load_board();
      @(negedge clk);
      start = 1'b1;
      e.lines = nl;
      e.done_cyc = -1;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 3000 && !(phase == 2'd2 && lines_cleared == 3'd1); k++) @(negedge clk);
      chk("t6_reach_shift2", 32'(phase == 2'd2 && lines_cleared == 3'd1), 32'd1);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #2;
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_phase", 32'(phase), 32'd0);
      chk("t6_we", 32'(ram_we), 32'd0);
      chk("t6_lines", 32'(lines_cleared), 32'd0);
      exp_q.delete();
      rst = 1'b1;
      for (int i = 0; i < NCELL; i++) init_mem[i] = mem[i];
    end
    run_pass(1'b0, d_t6);
    chk("t6_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
